// File: rtl/mips_mem_pkg.sv
// ============================================================================
//  Module : mips_mem_pkg
//  Brief  : Shared MEM-stage definitions: access-size codes, LSU FSM states
//           and the load lane-extract/extend helper.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } lsu_state_t;

    // Size code 2'b11 falls through to the full-word case.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_merge.sv
// ============================================================================
//  Module : store_merge
//  Brief  : Combinational sub-word store merge: overlays the right-justified
//           store data onto the addressed lane of an existing word.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module store_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = word_in;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
//  Module : mem_stage_lsu
//  Brief  : MEM-stage load/store unit in front of a word-wide dmem; sub-word
//           stores use a two-cycle read-modify-write with one stall cycle.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              align_err,
    output logic              range_err,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [31:0]       dmem_d,
    input  logic [31:0]       dmem_q
);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;

    logic        w_idle;
    logic        w_rmw;
    logic        w_is_word;
    logic        w_align_err;
    logic        w_range_err;
    logic        w_ok;
    logic        w_sub_store;
    logic [31:0] w_merged;

    // Outputs are gated by rst_n so they read as zero for the whole reset.
    assign w_idle    = rst_n & (r_state == ST_IDLE);
    assign w_rmw     = rst_n & (r_state == ST_RMW_WR);
    assign w_is_word = req_size[1];

    assign w_align_err = req_valid & w_idle &
                         (((req_size == SZ_HALF) & req_addr[0]) |
                          (w_is_word & (req_addr[1:0] != 2'b00)));
    assign w_range_err = req_valid & w_idle & (|req_addr[31:ADDR_W+2]);

    assign w_ok        = req_valid & w_idle & ~w_align_err & ~w_range_err;
    assign w_sub_store = w_ok & req_we & ~w_is_word;

    store_merge u_merge (
        .word_in (dmem_q),
        .wdata   (req_wdata),
        .size    (req_size),
        .lane    (req_addr[1:0]),
        .merged  (w_merged)
    );

    assign align_err = w_align_err;
    assign range_err = w_range_err;
    assign stall     = w_sub_store;
    assign dmem_we   = w_rmw | (w_ok & req_we & w_is_word);
    assign dmem_a    = w_rmw ? r_addr : req_addr[ADDR_W+1:2];
    assign dmem_d    = w_rmw ? r_data : req_wdata;
    assign load_data = (w_ok & ~req_we) ?
                       lane_extract(dmem_q, req_size, req_addr[1:0], req_signed) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sub_store) begin
                        r_addr  <= req_addr[ADDR_W+1:2];
                        r_data  <= w_merged;
                        r_state <= ST_RMW_WR;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
//  Module : tb_mem_stage_lsu
//  Brief  : Self-checking bench for mem_stage_lsu with an attached dmem and a
//           byte-lane arithmetic reference model of memory contents.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, align_err, range_err, dmem_we;
    logic [31:0] load_data, dmem_d, dmem_q;
    logic [5:0]  dmem_a;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [64];
    logic [5:0]  ram_ra;
    logic [31:0] ref_mem [64];
    logic [31:0] got_ld;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .align_err  (align_err),
        .range_err  (range_err),
        .dmem_we    (dmem_we),
        .dmem_a     (dmem_a),
        .dmem_d     (dmem_d),
        .dmem_q     (dmem_q)
    );

    // dmem: posedge write, negedge-latched read address
    always @(posedge clk) if (dmem_we) ram[dmem_a] <= dmem_d;
    always @(negedge clk) ram_ra <= dmem_a;
    assign dmem_q = ram[ram_ra];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sgn);
        logic [31:0] w, v;
        w = ref_mem[a[7:2]];
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] m;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * lane;
            m  = 32'hFF << sh;
        end else begin
            sh = 16 * lane[1];
            m  = 32'hFFFF << sh;
        end
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    task automatic op(input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [31:0] wd);
        logic        al, rg;
        logic [5:0]  idx;
        logic [31:0] mrg;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        @(negedge clk); #1;
        al  = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
        rg  = (a[31:8] != 24'd0);
        idx = a[7:2];
        got_ld = load_data;
        chk("align_err", {31'd0, align_err}, {31'd0, al});
        chk("range_err", {31'd0, range_err}, {31'd0, rg});
        if (al || rg) begin
            chk("err_stall", {31'd0, stall}, 32'd0);
            chk("err_we", {31'd0, dmem_we}, 32'd0);
            chk("err_ld", load_data, 32'd0);
        end else if (!we) begin
            chk("ld_stall", {31'd0, stall}, 32'd0);
            chk("ld_we", {31'd0, dmem_we}, 32'd0);
            chk("ld_data", load_data, model_load(a, sz, sgn));
        end else if (sz[1]) begin
            chk("sw_stall", {31'd0, stall}, 32'd0);
            chk("sw_we", {31'd0, dmem_we}, 32'd1);
            chk("sw_a", {26'd0, dmem_a}, {26'd0, idx});
            chk("sw_d", dmem_d, wd);
            ref_mem[idx] = wd;
        end else begin
            chk("rmw1_stall", {31'd0, stall}, 32'd1);
            chk("rmw1_we", {31'd0, dmem_we}, 32'd0);
            mrg = model_merge(ref_mem[idx], wd, sz, a[1:0]);
            @(posedge clk); #1;
            req_addr = $urandom; req_wdata = $urandom;   // must be ignored in RMW_WR
            @(negedge clk); #1;
            chk("rmw2_stall", {31'd0, stall}, 32'd0);
            chk("rmw2_we", {31'd0, dmem_we}, 32'd1);
            chk("rmw2_a", {26'd0, dmem_a}, {26'd0, idx});
            chk("rmw2_d", dmem_d, mrg);
            chk("rmw2_flags", {30'd0, align_err, range_err}, 32'd0);
            ref_mem[idx] = mrg;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        chk("idle_out", {29'd0, stall, dmem_we, align_err | range_err}, 32'd0);
        chk("idle_ld", load_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_signed = 1'b1; req_addr = 32'h0000_0013; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        chk("rst_out", {29'd0, stall, dmem_we, align_err | range_err}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;

        // 1: sw then lw
        op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("t1_lw", got_ld, 32'hDEADBEEF);
        // 2: sb and signed/unsigned byte loads
        op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
        op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        chk("t2_lb", got_ld, 32'hFFFFFFAB);
        op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        chk("t2_lbu", got_ld, 32'h000000AB);
        // 3: sh, misaligned lh/sh
        op(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        op(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
        op(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000FFFF);
        idle_cycle();
        chk("t3_word", ram[4], 32'h1234ABEF);
        // 4: out-of-range store
        op(1'b1, 2'd2, 1'b0, 32'h100, 32'h01020304);
        idle_cycle();
        chk("t4_word0", ram[0], 32'h0);
        // 5: sb immediately followed by lw of the same word
        op(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000077);
        op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("t5_lw", got_ld, 32'h123477EF);

        // 6: reset during the RMW_WR cycle of sb 0x55 @0x10
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(negedge clk); #1;
        chk("t6_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("t6_rmw_we", {31'd0, dmem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_we", {30'd0, dmem_we, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;
        chk("t6_post_out", {30'd0, dmem_we, stall}, 32'd0);
        chk("t6_word", ram[4], 32'h123477EF);
        op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Random traffic against the memory model
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 255);
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();
        for (int i = 0; i < 64; i++) chk("ram_final", ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
